// File: rtl/dma_pkg.sv
// Shared types and sizing helpers for the cache-line DMA master.
package dma_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        DONE     = 3'd4
    } dma_state_e;

    // Number of bus beats per cache line.
    function automatic int unsigned beats_f(input int unsigned block_words,
                                            input int unsigned beat_words);
        return block_words / beat_words;
    endfunction

    // Number of byte-offset bits inside a cache line.
    function automatic int unsigned off_w_f(input int unsigned block_words);
        return $clog2(block_words * 4);
    endfunction

    // Width of a beat slot index; never zero so single-beat lines still elaborate.
    function automatic int unsigned idx_w_f(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/dma_line_master.sv
// Cache-line DMA master: splits fills/writebacks into bus beats and reassembles fill data.
// Optional DMA_PIPELINE_EN overlaps read-beat issue with response collection.
module dma_line_master
    import dma_pkg::*;
#(
    parameter int unsigned block_size_p     = 8,
    parameter int unsigned dma_data_width_p = 2,
    parameter int unsigned addr_width_p     = 32
) (
    input  logic                                clk_i,
    input  logic                                nreset_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic                                req_we_i,
    input  logic [addr_width_p-1:0]             req_addr_i,
    input  logic [block_size_p*32-1:0]          req_wdata_i,
    output logic                                resp_valid_o,
    output logic [block_size_p*32-1:0]          resp_rdata_o,
    output logic                                mem_valid_o,
    input  logic                                mem_ready_i,
    output logic                                mem_we_o,
    output logic [addr_width_p-1:0]             mem_addr_o,
    output logic [dma_data_width_p*32-1:0]      mem_wdata_o,
    input  logic                                mem_valid_i,
    input  logic [dma_data_width_p*32-1:0]      mem_data_i
);

    localparam int unsigned BEATS      = beats_f(block_size_p, dma_data_width_p);
    localparam int unsigned BEAT_BITS  = dma_data_width_p * WORD_BITS;
    localparam int unsigned LINE_BITS  = block_size_p * WORD_BITS;
    localparam int unsigned BEAT_SHIFT = $clog2(dma_data_width_p * 4);
    localparam int unsigned OFF_W      = off_w_f(block_size_p);
    localparam int unsigned CNT_W      = $clog2(BEATS + 1);
    localparam int unsigned IDX_W      = idx_w_f(BEATS);
    localparam logic [addr_width_p-1:0] LINE_MASK = addr_width_p'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    dma_state_e                 r_state, w_state_nxt;
    logic [addr_width_p-1:0]    r_base, w_base_nxt;
    logic                       r_we, w_we_nxt;
    logic [LINE_BITS-1:0]       r_line, w_line_nxt;
    logic [CNT_W-1:0]           r_iss_cnt, w_iss_nxt;
`ifdef DMA_PIPELINE_EN
    logic [CNT_W-1:0]           r_ret_cnt, w_ret_nxt;
`endif
    logic [IDX_W-1:0]           w_slot;
    logic [addr_width_p-1:0]    w_beat_addr;

    logic                       r_req_ready;
    logic                       r_resp_valid;
    logic [LINE_BITS-1:0]       r_resp_rdata;
    logic                       r_mem_valid;
    logic                       r_mem_we;
    logic [addr_width_p-1:0]    r_mem_addr;
    logic [BEAT_BITS-1:0]       r_mem_wdata;

    // Read data lands in the slot of the beat being returned.
`ifdef DMA_PIPELINE_EN
    assign w_slot = IDX_W'(r_ret_cnt);
`else
    assign w_slot = IDX_W'(r_iss_cnt);
`endif

    // Next-state, counter and line-buffer update.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_we_nxt    = r_we;
        w_line_nxt  = r_line;
        w_iss_nxt   = r_iss_cnt;
`ifdef DMA_PIPELINE_EN
        w_ret_nxt   = r_ret_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_base_nxt  = req_addr_i & ~LINE_MASK;
                    w_we_nxt    = req_we_i;
                    w_line_nxt  = req_we_i ? req_wdata_i : r_line;
                    w_iss_nxt   = '0;
`ifdef DMA_PIPELINE_EN
                    w_ret_nxt   = '0;
`endif
                    w_state_nxt = req_we_i ? WRITE : RD_ISSUE;
                end
            end
            WRITE: begin
                if (mem_ready_i) begin
                    w_iss_nxt = r_iss_cnt + CNT_W'(1);
                    if (r_iss_cnt == LAST_BEAT) w_state_nxt = DONE;
                end
            end
`ifdef DMA_PIPELINE_EN
            RD_ISSUE: begin
                if (mem_ready_i) begin
                    w_iss_nxt = r_iss_cnt + CNT_W'(1);
                    if (r_iss_cnt == LAST_BEAT) w_state_nxt = RD_WAIT;
                end
                // Responses only count against beats already issued.
                if (mem_valid_i && (r_ret_cnt < r_iss_cnt)) begin
                    w_line_nxt[w_slot*BEAT_BITS +: BEAT_BITS] = mem_data_i;
                    w_ret_nxt = r_ret_cnt + CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (mem_valid_i && (r_ret_cnt < r_iss_cnt)) begin
                    w_line_nxt[w_slot*BEAT_BITS +: BEAT_BITS] = mem_data_i;
                    w_ret_nxt = r_ret_cnt + CNT_W'(1);
                    if (r_ret_cnt == LAST_BEAT) w_state_nxt = DONE;
                end
            end
`else
            RD_ISSUE: begin
                if (mem_ready_i) w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_valid_i) begin
                    w_line_nxt[w_slot*BEAT_BITS +: BEAT_BITS] = mem_data_i;
                    w_iss_nxt   = r_iss_cnt + CNT_W'(1);
                    w_state_nxt = (r_iss_cnt == LAST_BEAT) ? DONE : RD_ISSUE;
                end
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_beat_addr = w_base_nxt + (addr_width_p'(w_iss_nxt) << BEAT_SHIFT);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_we      <= 1'b0;
            r_line    <= '0;
            r_iss_cnt <= '0;
`ifdef DMA_PIPELINE_EN
            r_ret_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_we      <= w_we_nxt;
            r_line    <= w_line_nxt;
            r_iss_cnt <= w_iss_nxt;
`ifdef DMA_PIPELINE_EN
            r_ret_cnt <= w_ret_nxt;
`endif
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == DONE);
            if ((w_state_nxt == DONE) && !w_we_nxt) r_resp_rdata <= w_line_nxt;
            r_mem_valid  <= (w_state_nxt == WRITE) || (w_state_nxt == RD_ISSUE);
            r_mem_we     <= (w_state_nxt == WRITE);
            r_mem_addr   <= w_beat_addr;
            r_mem_wdata  <= (w_state_nxt == WRITE)
                          ? w_line_nxt[IDX_W'(w_iss_nxt)*BEAT_BITS +: BEAT_BITS] : '0;
        end
    end

    assign req_ready_o  = r_req_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_resp_rdata;
    assign mem_valid_o  = r_mem_valid;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_dma_line_master.sv
// Scoreboard bench for dma_line_master: driver queues expected beats/responses, monitor checks them.
module tb_dma_line_master;

    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned BEAT_BITS = 64;
`ifdef DMA_PIPELINE_EN
    localparam int unsigned FILL_LAT = 6;
    localparam int unsigned RST_WAIT = 3;
`else
    localparam int unsigned FILL_LAT = 9;
    localparam int unsigned RST_WAIT = 5;
`endif

    logic                  clk_i = 1'b0;
    logic                  nreset_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [31:0]           req_addr_i;
    logic [LINE_BITS-1:0]  req_wdata_i;
    logic                  resp_valid_o;
    logic [LINE_BITS-1:0]  resp_rdata_o;
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic                  mem_we_o;
    logic [31:0]           mem_addr_o;
    logic [BEAT_BITS-1:0]  mem_wdata_o;
    logic                  mem_valid_i;
    logic [BEAT_BITS-1:0]  mem_data_i;

    dma_line_master #(
        .block_size_p     (8),
        .dma_data_width_p (2),
        .addr_width_p     (32)
    ) u_dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit                   is_resp;
        bit                   we;
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
        int unsigned          at_cyc;
    } exp_t;

    exp_t                 exp_q[$];
    int                   n_vec = 0;
    int                   n_err = 0;
    logic                 spur = 1'b0;
    logic [LINE_BITS-1:0] held = '0;

    localparam logic [LINE_BITS-1:0] WB_LINE = {32'h88, 32'h77, 32'h66, 32'h55,
                                                32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [LINE_BITS-1:0] LINE_2000 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [LINE_BITS-1:0] LINE_5000 = {64'h3A3, 64'h3A2, 64'h3A1, 64'h3A0};

    task automatic chk(input string nm, input logic [LINE_BITS-1:0] act,
                       input logic [LINE_BITS-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_pop(input bit is_resp);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected %s at cycle %0d", is_resp ? "resp" : "beat", cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event kind", LINE_BITS'(is_resp), LINE_BITS'(e.is_resp));
        if (is_resp != e.is_resp) return;
        if (!is_resp) begin
            chk("beat we", LINE_BITS'(mem_we_o), LINE_BITS'(e.we));
            chk("beat addr", LINE_BITS'(mem_addr_o), LINE_BITS'(e.addr));
            if (e.we) chk("beat wdata", LINE_BITS'(mem_wdata_o), e.data);
        end else begin
            chk("resp rdata", resp_rdata_o, e.data);
            chk("resp cycle", LINE_BITS'(cyc + 1), LINE_BITS'(e.at_cyc));
        end
    endtask

    // Monitor: compare every bus handshake and completion against the queue.
    always @(negedge clk_i) begin
        if (nreset_i) begin
            if (mem_valid_o && mem_ready_i) check_pop(1'b0);
            if (resp_valid_o) check_pop(1'b1);
        end
    end

    function automatic logic [BEAT_BITS-1:0] rd_beat(input logic [31:0] a);
        logic [BEAT_BITS-1:0] hi;
        hi = (BEAT_BITS'(a[15:12]) - 64'd2) << 8;
        return hi | (64'hA0 + BEAT_BITS'(a[4:3]));
    endfunction

    // Memory model: answers each read handshake one cycle later; spur injects junk beats.
    logic        rsp_hs;
    logic [31:0] rsp_addr;
    initial begin
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        forever begin
            @(posedge clk_i);
            rsp_hs   = mem_valid_o && mem_ready_i && !mem_we_o;
            rsp_addr = mem_addr_o;
            #2;
            mem_valid_i = rsp_hs || spur;
            mem_data_i  = rsp_hs ? rd_beat(rsp_addr) : 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] base,
                        input logic [LINE_BITS-1:0] line, input int nbeats,
                        input bit with_resp, input int unsigned lat);
        exp_t e;
        int   t = 0;
        while (!req_ready_o && t < 50) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("req_ready before request", LINE_BITS'(req_ready_o), LINE_BITS'(1));
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = we ? line : {8{32'hCAFE_F00D}};
        for (int k = 0; k < nbeats; k++) begin
            e.is_resp = 1'b0;
            e.we      = we;
            e.addr    = base + 32'(k * 8);
            e.data    = we ? LINE_BITS'(line[k*BEAT_BITS +: BEAT_BITS]) : '0;
            e.at_cyc  = 0;
            exp_q.push_back(e);
        end
        if (with_resp) begin
            if (!we) held = line;
            e.is_resp = 1'b1;
            e.we      = we;
            e.addr    = '0;
            e.data    = held;
            e.at_cyc  = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !req_ready_o) && t < 60) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("scoreboard drained", LINE_BITS'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nreset_i    = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset req_ready", LINE_BITS'(req_ready_o), LINE_BITS'(1));
        chk("reset resp_valid", LINE_BITS'(resp_valid_o), '0);
        chk("reset mem_valid", LINE_BITS'(mem_valid_o), '0);
        chk("reset mem_we", LINE_BITS'(mem_we_o), '0);
        chk("reset mem_addr", LINE_BITS'(mem_addr_o), '0);
        chk("reset mem_wdata", LINE_BITS'(mem_wdata_o), '0);
        chk("reset resp_rdata", resp_rdata_o, '0);
        nreset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Writeback with unaligned address, memory always ready.
        send(1'b1, 32'h0000_1034, 32'h0000_1020, WB_LINE, 4, 1'b1, 5);
        drain();

        // Fill with one-cycle memory.
        send(1'b0, 32'h0000_2000, 32'h0000_2000, LINE_2000, 4, 1'b1, FILL_LAT);
        drain();

        // Writeback with beat 1 stalled three cycles.
        send(1'b1, 32'h0000_3008, 32'h0000_3000, WB_LINE, 4, 1'b1, 8);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall valid", LINE_BITS'(mem_valid_o), LINE_BITS'(1));
            chk("stall addr", LINE_BITS'(mem_addr_o), LINE_BITS'(32'h0000_3008));
            chk("stall wdata", LINE_BITS'(mem_wdata_o), LINE_BITS'(64'h0000_0044_0000_0033));
            @(posedge clk_i);
            #1;
        end
        mem_ready_i = 1'b1;
        drain();

        // Spurious read beats while idle and during a writeback.
        spur = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            chk("spur idle req_ready", LINE_BITS'(req_ready_o), LINE_BITS'(1));
            chk("spur idle resp_valid", LINE_BITS'(resp_valid_o), '0);
            chk("spur idle rdata", resp_rdata_o, LINE_2000);
        end
        send(1'b1, 32'h0000_1034, 32'h0000_1020, WB_LINE, 4, 1'b1, 5);
        drain();
        spur = 1'b0;

        // Reset in the middle of a fill.
        send(1'b0, 32'h0000_4000, 32'h0000_4000, '0, 3, 1'b0, 0);
        repeat (RST_WAIT) @(posedge clk_i);
        #2;
        nreset_i = 1'b0;
        #1;
        chk("midreset mem_valid", LINE_BITS'(mem_valid_o), '0);
        chk("midreset req_ready", LINE_BITS'(req_ready_o), LINE_BITS'(1));
        chk("midreset resp_valid", LINE_BITS'(resp_valid_o), '0);
        chk("midreset rdata", resp_rdata_o, '0);
        held = '0;
        @(posedge clk_i);
        #1;
        nreset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        drain();

        // Fresh fill after the aborted one.
        send(1'b0, 32'h0000_5010, 32'h0000_5000, LINE_5000, 4, 1'b1, FILL_LAT);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
